// File: rtl/oursring_rbus_bridge.sv
// Oursring endpoint that turns single-beat AW/W or AR requests into one local
// register-bus access at a time, with address decode and a response timeout.

package oursring_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [7:0]  awid;
    logic [39:0] awaddr;
  } oursring_req_if_aw_t;

  typedef struct packed {
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
  } oursring_req_if_w_t;

  typedef struct packed {
    logic [7:0]  arid;
    logic [39:0] araddr;
  } oursring_req_if_ar_t;

  typedef struct packed {
    logic [7:0] bid;
    logic [1:0] bresp;
  } oursring_resp_if_b_t;

  typedef struct packed {
    logic [7:0]  rid;
    logic [63:0] rdata;
    logic        rlast;
    logic [1:0]  rresp;
  } oursring_resp_if_r_t;
endpackage

module oursring_rbus_bridge
  import oursring_pkg::*;
#(
  parameter logic [39:0] BASE_ADDR = 40'h0,
  parameter logic [39:0] WIN_SIZE  = 40'h1_0000,
  parameter int          RBUS_AW   = 16,
  parameter int          TIMEOUT   = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_awvalid,
  input  oursring_req_if_aw_t req_aw,
  output logic                req_awready,
  input  logic                req_wvalid,
  input  oursring_req_if_w_t  req_w,
  output logic                req_wready,
  input  logic                req_arvalid,
  input  oursring_req_if_ar_t req_ar,
  output logic                req_arready,
  output logic                rsp_bvalid,
  output oursring_resp_if_b_t rsp_b,
  input  logic                rsp_bready,
  output logic                rsp_rvalid,
  output oursring_resp_if_r_t rsp_r,
  input  logic                rsp_rready,
  output logic                rbus_req_valid,
  output logic                rbus_req_we,
  output logic [RBUS_AW-1:0]  rbus_req_addr,
  output logic [63:0]         rbus_req_wdata,
  output logic [7:0]          rbus_req_wstrb,
  input  logic                rbus_req_ready,
  input  logic                rbus_rsp_valid,
  input  logic [63:0]         rbus_rsp_rdata,
  input  logic                rbus_rsp_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, BRESP, RRESP} state_t;

  state_t              state_q, state_d;
  logic                wr_pri_q;
  logic                we_q;
  logic [7:0]          id_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [RBUS_AW-1:0]  req_addr_q;
  logic [63:0]         req_wdata_q;
  logic [7:0]          req_wstrb_q;
  oursring_resp_if_b_t rsp_b_q;
  oursring_resp_if_r_t rsp_r_q;

  logic        grant_w, grant_r, hit;
  logic        load_rsp, rsp_is_w;
  logic [7:0]  rsp_id;
  logic [1:0]  rsp_resp;
  logic [63:0] rsp_rdata;
  logic        cnt_clr, cnt_inc;
  logic [39:0] grant_addr;

  // Every write is single-beat, so wlast carries no information.
  logic unused_wlast;
  assign unused_wlast = req_w.wlast;

  function automatic logic addr_hit(input logic [39:0] a);
    return (a & ~(WIN_SIZE - 40'd1)) == BASE_ADDR;
  endfunction

  function automatic logic [RBUS_AW-1:0] addr_off(input logic [39:0] a);
    logic [39:0] d;
    d = a - BASE_ADDR;
    return d[RBUS_AW-1:0];
  endfunction

  assign grant_addr = grant_w ? req_aw.awaddr : req_ar.araddr;

  always_comb begin
    state_d   = state_q;
    grant_w   = 1'b0;
    grant_r   = 1'b0;
    hit       = 1'b0;
    load_rsp  = 1'b0;
    rsp_is_w  = we_q;
    rsp_id    = id_q;
    rsp_resp  = RESP_OKAY;
    rsp_rdata = '0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        // No grants while reset is held, so readies stay low during reset.
        if (!rst) begin
          grant_w = req_awvalid && req_wvalid && (wr_pri_q || !req_arvalid);
          grant_r = req_arvalid && !grant_w;
          if (grant_w) begin
            hit      = addr_hit(req_aw.awaddr);
            rsp_id   = req_aw.awid;
            rsp_is_w = 1'b1;
          end else if (grant_r) begin
            hit      = addr_hit(req_ar.araddr);
            rsp_id   = req_ar.arid;
            rsp_is_w = 1'b0;
          end
          if (grant_w || grant_r) begin
            if (hit) begin
              state_d = ISSUE;
            end else begin
              load_rsp = 1'b1;
              rsp_resp = RESP_DECERR;
              state_d  = grant_w ? BRESP : RRESP;
            end
          end
        end
      end
      ISSUE: begin
        if (rbus_req_ready) begin
          cnt_clr = 1'b1;
          if (rbus_rsp_valid) begin
            load_rsp  = 1'b1;
            rsp_resp  = rbus_rsp_err ? RESP_SLVERR : RESP_OKAY;
            rsp_rdata = rbus_rsp_rdata;
            state_d   = we_q ? BRESP : RRESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_inc = 1'b1;
        if (rbus_rsp_valid) begin
          load_rsp  = 1'b1;
          rsp_resp  = rbus_rsp_err ? RESP_SLVERR : RESP_OKAY;
          rsp_rdata = rbus_rsp_rdata;
          state_d   = we_q ? BRESP : RRESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          load_rsp = 1'b1;
          rsp_resp = RESP_SLVERR;
          state_d  = we_q ? BRESP : RRESP;
        end
      end
      BRESP: if (rsp_bready) state_d = IDLE;
      RRESP: if (rsp_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_pri_q    <= 1'b1;
      we_q        <= 1'b0;
      id_q        <= '0;
      cnt_q       <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      rsp_b_q     <= '0;
      rsp_r_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_w) wr_pri_q <= 1'b0;
      else if (grant_r) wr_pri_q <= 1'b1;
      if ((grant_w || grant_r) && hit) begin
        we_q        <= grant_w;
        id_q        <= rsp_id;
        req_addr_q  <= addr_off(grant_addr);
        req_wdata_q <= grant_w ? req_w.wdata : 64'h0;
        req_wstrb_q <= grant_w ? req_w.wstrb : 8'h00;
      end
      if (cnt_clr) cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      if (load_rsp) begin
        if (rsp_is_w) rsp_b_q <= '{bid: rsp_id, bresp: rsp_resp};
        else rsp_r_q <= '{rid: rsp_id, rdata: rsp_rdata, rlast: 1'b1, rresp: rsp_resp};
      end
    end
  end

  assign req_awready    = grant_w;
  assign req_wready     = grant_w;
  assign req_arready    = grant_r;
  assign rbus_req_valid = (state_q == ISSUE);
  assign rbus_req_we    = we_q;
  assign rbus_req_addr  = req_addr_q;
  assign rbus_req_wdata = req_wdata_q;
  assign rbus_req_wstrb = req_wstrb_q;
  assign rsp_bvalid     = (state_q == BRESP);
  assign rsp_b          = rsp_b_q;
  assign rsp_rvalid     = (state_q == RRESP);
  assign rsp_r          = rsp_r_q;

endmodule

// File: tb/tb_oursring_rbus_bridge.sv
// Directed bench for oursring_rbus_bridge: ring transactions, arbitration,
// decode errors, timeout, backpressure and mid-transaction reset.

module tb_oursring_rbus_bridge;
  import oursring_pkg::*;

  localparam logic [39:0] BASE = 40'h00_8000_0000;
  localparam logic [39:0] WIN  = 40'h00_0001_0000;
  localparam int          RW   = 75;

  logic                clk, rst;
  logic                req_awvalid, req_wvalid, req_arvalid;
  oursring_req_if_aw_t req_aw;
  oursring_req_if_w_t  req_w;
  oursring_req_if_ar_t req_ar;
  logic                req_awready, req_wready, req_arready;
  logic                rsp_bvalid, rsp_bready, rsp_rvalid, rsp_rready;
  oursring_resp_if_b_t rsp_b;
  oursring_resp_if_r_t rsp_r;
  logic                rbus_req_valid, rbus_req_we, rbus_req_ready;
  logic [15:0]         rbus_req_addr;
  logic [63:0]         rbus_req_wdata;
  logic [7:0]          rbus_req_wstrb;
  logic                rbus_rsp_valid, rbus_rsp_err;
  logic [63:0]         rbus_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];
  logic [2:0] arb_order [4];

  oursring_rbus_bridge #(
    .BASE_ADDR(BASE), .WIN_SIZE(WIN), .RBUS_AW(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_awvalid(req_awvalid), .req_aw(req_aw), .req_awready(req_awready),
    .req_wvalid(req_wvalid), .req_w(req_w), .req_wready(req_wready),
    .req_arvalid(req_arvalid), .req_ar(req_ar), .req_arready(req_arready),
    .rsp_bvalid(rsp_bvalid), .rsp_b(rsp_b), .rsp_bready(rsp_bready),
    .rsp_rvalid(rsp_rvalid), .rsp_r(rsp_r), .rsp_rready(rsp_rready),
    .rbus_req_valid(rbus_req_valid), .rbus_req_we(rbus_req_we),
    .rbus_req_addr(rbus_req_addr), .rbus_req_wdata(rbus_req_wdata),
    .rbus_req_wstrb(rbus_req_wstrb), .rbus_req_ready(rbus_req_ready),
    .rbus_rsp_valid(rbus_rsp_valid), .rbus_rsp_rdata(rbus_rsp_rdata),
    .rbus_rsp_err(rbus_rsp_err)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_write(input logic [7:0] id, input logic [39:0] addr,
                            input logic [63:0] data, input logic [7:0] strb);
    int n;
    n = 0;
    @(negedge clk);
    req_awvalid = 1'b1; req_aw.awid = id; req_aw.awaddr = addr;
    req_wvalid  = 1'b1; req_w.wdata = data; req_w.wstrb = strb; req_w.wlast = 1'b1;
    #1;
    while (!req_awready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("wr_accept", {req_awready, req_wready, req_arready, rbus_req_valid}, 4'b1100);
    @(negedge clk);
    req_awvalid = 1'b0; req_wvalid = 1'b0;
  endtask

  task automatic send_read(input logic [7:0] id, input logic [39:0] addr);
    int n;
    n = 0;
    @(negedge clk);
    req_arvalid = 1'b1; req_ar.arid = id; req_ar.araddr = addr;
    #1;
    while (!req_arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rd_accept", {req_awready, req_wready, req_arready, rbus_req_valid}, 4'b0010);
    @(negedge clk);
    req_arvalid = 1'b0;
  endtask

  // Holds rbus_req_ready low for 'stall' cycles, checking payload stability;
  // optionally pulses rbus_rsp_valid at cycle 'stray' while not ready.
  task automatic rbus_serve(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                            input logic [7:0] strb, input int stall, input int stray);
    for (int i = 0; i <= stall; i++) begin
      #1;
      chk("rbus_req", {rbus_req_valid, rbus_req_we, rbus_req_addr,
                       (we ? rbus_req_wdata : 64'h0), rbus_req_wstrb},
                      {1'b1, we, addr, wdata, strb});
      rbus_rsp_valid = (i == stray);
      if (i == stall) rbus_req_ready = 1'b1;
      @(negedge clk);
    end
    rbus_req_ready = 1'b0;
    rbus_rsp_valid = 1'b0;
  endtask

  task automatic rbus_respond(input logic [63:0] rdata, input logic err);
    rbus_rsp_valid = 1'b1; rbus_rsp_rdata = rdata; rbus_rsp_err = err;
    @(negedge clk);
    rbus_rsp_valid = 1'b0; rbus_rsp_err = 1'b0;
  endtask

  // Scoreboard: pops the expected response and checks it stays stable under backpressure.
  task automatic expect_rsp(input logic is_w, input int stall);
    logic [RW-1:0] exp;
    exp = exp_q.pop_front();
    for (int i = 0; i <= stall; i++) begin
      #1;
      if (is_w) chk("b_rsp", {rsp_bvalid, rsp_rvalid, RW'(rsp_b)}, {2'b10, exp});
      else      chk("r_rsp", {rsp_bvalid, rsp_rvalid, rsp_r}, {2'b01, exp});
      if (i == stall) begin
        if (is_w) rsp_bready = 1'b1;
        else      rsp_rready = 1'b1;
      end
      @(negedge clk);
    end
    rsp_bready = 1'b0; rsp_rready = 1'b0;
    #1;
    chk("rsp_drop", {rsp_bvalid, rsp_rvalid}, 2'b00);
  endtask

  initial begin
    int k;
    arb_order[0] = 3'b110; arb_order[1] = 3'b001;
    arb_order[2] = 3'b110; arb_order[3] = 3'b001;
    rst = 1'b1;
    req_awvalid = 1'b0; req_wvalid = 1'b0; req_arvalid = 1'b0;
    req_aw = '0; req_w = '0; req_ar = '0;
    rsp_bready = 1'b0; rsp_rready = 1'b0;
    rbus_req_ready = 1'b0; rbus_rsp_valid = 1'b0; rbus_rsp_rdata = '0; rbus_rsp_err = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {req_awready, req_wready, req_arready}, 3'b000);
    chk("rst_valid", {rsp_bvalid, rsp_rvalid, rbus_req_valid}, 3'b000);
    chk("rst_rbus_payload", {rbus_req_we, rbus_req_addr, rbus_req_wdata, rbus_req_wstrb}, 0);
    chk("rst_rsp_payload", {rsp_b, rsp_r}, 0);

    // All three requests held from reset: grants alternate W, R, W, R
    req_awvalid = 1'b1; req_wvalid = 1'b1; req_arvalid = 1'b1;
    req_aw = '{awid: 8'h01, awaddr: BASE + 40'h20};
    req_w  = '{wdata: 64'h0BAD_F00D_1234_5678, wstrb: 8'hFF, wlast: 1'b1};
    req_ar = '{arid: 8'h02, araddr: BASE + 40'h28};
    rbus_req_ready = 1'b1; rbus_rsp_valid = 1'b1; rbus_rsp_rdata = 64'h5555_AAAA_0F0F_F0F0;
    rsp_bready = 1'b1; rsp_rready = 1'b1;
    #1;
    chk("rst_ready_held", {req_awready, req_wready, req_arready}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      #1;
      if (rsp_bvalid || rsp_rvalid) chk("no_issue_while_rsp", rbus_req_valid, 1'b0);
      if (rsp_bvalid) chk("arb_b", rsp_b, {8'h01, RESP_OKAY});
      if (rsp_rvalid) chk("arb_r", rsp_r, {8'h02, 64'h5555_AAAA_0F0F_F0F0, 1'b1, RESP_OKAY});
      if (req_awready || req_wready || req_arready) begin
        chk("arb_grant", {req_awready, req_wready, req_arready}, arb_order[k]);
        k++;
      end
      @(negedge clk);
    end
    chk("arb_count", k, 4);
    req_awvalid = 1'b0; req_wvalid = 1'b0; req_arvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("arb_last_r", {rsp_rvalid, rsp_r}, {1'b1, 8'h02, 64'h5555_AAAA_0F0F_F0F0, 1'b1, RESP_OKAY});
    @(negedge clk);
    rbus_req_ready = 1'b0; rbus_rsp_valid = 1'b0; rsp_bready = 1'b0; rsp_rready = 1'b0;
    #1;
    chk("arb_idle", {rsp_bvalid, rsp_rvalid, rbus_req_valid}, 3'b000);

    // Basic write
    send_write(8'h03, BASE + 40'h10, 64'hDEAD_BEEF_0123_4567, 8'h0F);
    rbus_serve(1'b1, 16'h0010, 64'hDEAD_BEEF_0123_4567, 8'h0F, 0, -1);
    #1;
    chk("wait_no_b", {rsp_bvalid, rbus_req_valid}, 2'b00);
    rbus_respond(64'h0, 1'b0);
    exp_q.push_back(RW'({8'h03, RESP_OKAY}));
    expect_rsp(1'b1, 0);

    // Basic read, then read with slave error
    send_read(8'h05, BASE + 40'h8);
    rbus_serve(1'b0, 16'h0008, 64'h0, 8'h00, 0, -1);
    rbus_respond(64'h1122_3344_5566_7788, 1'b0);
    exp_q.push_back({8'h05, 64'h1122_3344_5566_7788, 1'b1, RESP_OKAY});
    expect_rsp(1'b0, 0);
    send_read(8'h05, BASE + 40'h8);
    rbus_serve(1'b0, 16'h0008, 64'h0, 8'h00, 0, -1);
    rbus_respond(64'hCAFE_F00D_0000_1234, 1'b1);
    exp_q.push_back({8'h05, 64'hCAFE_F00D_0000_1234, 1'b1, RESP_SLVERR});
    expect_rsp(1'b0, 0);

    // Decode misses: just past the window (read) and just below it (write)
    send_read(8'h07, BASE + WIN);
    #1;
    chk("decerr_rd_no_rbus", rbus_req_valid, 1'b0);
    exp_q.push_back({8'h07, 64'h0, 1'b1, RESP_DECERR});
    expect_rsp(1'b0, 0);
    send_write(8'h0C, BASE - 40'h8, 64'h1, 8'h01);
    #1;
    chk("decerr_wr_no_rbus", rbus_req_valid, 1'b0);
    exp_q.push_back(RW'({8'h0C, RESP_DECERR}));
    expect_rsp(1'b1, 0);

    // Timeout: eight silent wait cycles, then SLVERR; a later stray response is ignored
    send_write(8'h09, BASE + 40'h40, 64'h0123_4567_89AB_CDEF, 8'hF0);
    rbus_serve(1'b1, 16'h0040, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, -1);
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("timeout_wait", {rsp_bvalid, rbus_req_valid}, 2'b00);
      @(negedge clk);
    end
    exp_q.push_back(RW'({8'h09, RESP_SLVERR}));
    expect_rsp(1'b1, 0);
    rbus_respond(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stray_ignored", {rsp_bvalid, rsp_rvalid, rbus_req_valid}, 3'b000);
      @(negedge clk);
    end

    // Backpressure on both buses, with a response pulse during the rbus stall
    send_write(8'h0A, BASE + 40'h100, 64'hA5A5_5A5A_F00F_0FF0, 8'hFF);
    rbus_serve(1'b1, 16'h0100, 64'hA5A5_5A5A_F00F_0FF0, 8'hFF, 5, 2);
    rbus_respond(64'h0, 1'b0);
    exp_q.push_back(RW'({8'h0A, RESP_OKAY}));
    expect_rsp(1'b1, 3);

    // Reset while waiting on the rbus drops the transaction
    send_write(8'h0B, BASE + 40'h200, 64'h1357_9BDF_2468_ACE0, 8'h3C);
    rbus_serve(1'b1, 16'h0200, 64'h1357_9BDF_2468_ACE0, 8'h3C, 0, -1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valids", {req_awready, req_wready, req_arready,
                           rsp_bvalid, rsp_rvalid, rbus_req_valid}, 6'b000000);
    chk("rst_mid_payload", {rbus_req_addr, rbus_req_wstrb, rsp_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    rbus_respond(64'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rst_no_rsp", {rsp_bvalid, rsp_rvalid, rbus_req_valid}, 3'b000);
      @(negedge clk);
    end
    send_write(8'h0D, BASE + 40'h18, 64'h7777_8888_9999_0000, 8'h81);
    rbus_serve(1'b1, 16'h0018, 64'h7777_8888_9999_0000, 8'h81, 0, -1);
    rbus_respond(64'h0, 1'b0);
    exp_q.push_back(RW'({8'h0D, RESP_OKAY}));
    expect_rsp(1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
